// File: rtl/mips_instr_encoder.sv
// Builds 32-bit MIPS instruction words from mnemonic-level requests and writes them at a running PC.
// Optional ENCODER_CHECKSUM_EN adds a running XOR checksum of written words.
module mips_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [15:0]       imm_i,
  input  logic [31:0]       target_i,
  input  logic              flush_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              err_valid_o,
  output logic [1:0]        err_code_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] count_o
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE} state_e;

  localparam logic [ADDR_W-1:0] BASE_L      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MEM_WORDS_L = ADDR_W'(MEM_WORDS);
  localparam logic [1:0] ERR_ILLEGAL = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [15:0]       imm_q, imm_d;
  logic [31:0]       target_q, target_d;
  logic [ADDR_W-1:0] pc_q, pc_d, count_q, count_d, addr_q, addr_d;
  logic              full_q, full_d, we_q, we_d, err_valid_q, err_valid_d;
  logic [31:0]       data_q, data_d, chk_q, chk_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0]        npc, diff;
  logic signed [31:0] off;
  logic               off_bad, enc_err;
  logic [1:0]         enc_code;
  logic [31:0]        word;

  // Branch/jump reference point is pc+4, with pc zero-extended to 32 bits.
  always_comb begin
    npc      = {{(32-ADDR_W){1'b0}}, pc_q} + 32'd4;
    diff     = target_q - npc;
    off      = $signed(diff) >>> 2;
    off_bad  = !((&off[31:15]) || (~|off[31:15]));
    enc_err  = 1'b0;
    enc_code = ERR_ILLEGAL;
    word     = 32'h0;
    case (op_q)
      4'd0:  word = {6'h00, rs_q, rt_q, rd_q, 5'b0, 6'h20};
      4'd1:  word = {6'h00, rs_q, rt_q, rd_q, 5'b0, 6'h22};
      4'd2:  word = {6'h00, rs_q, rt_q, rd_q, 5'b0, 6'h2A};
      4'd3:  word = {6'h00, rs_q, 15'b0, 6'h08};
      4'd4:  word = {6'h23, rs_q, rt_q, imm_q};
      4'd5:  word = {6'h2B, rs_q, rt_q, imm_q};
      4'd10: word = {6'h0E, rs_q, rt_q, imm_q};
      4'd11: word = {6'h08, rs_q, rt_q, imm_q};
      4'd6, 4'd7: begin
        word = {(op_q == 4'd6) ? 6'h02 : 6'h03, target_q[27:2]};
        if (target_q[1:0] != 2'b00) begin
          enc_err  = 1'b1;
          enc_code = ERR_ALIGN;
        end else if (target_q[31:28] != npc[31:28]) begin
          enc_err  = 1'b1;
          enc_code = ERR_RANGE;
        end
      end
      4'd8, 4'd9: begin
        word = {(op_q == 4'd8) ? 6'h04 : 6'h05, rs_q, rt_q, off[15:0]};
        if (target_q[1:0] != 2'b00) begin
          enc_err  = 1'b1;
          enc_code = ERR_ALIGN;
        end else if (off_bad) begin
          enc_err  = 1'b1;
          enc_code = ERR_RANGE;
        end
      end
      default: begin
        enc_err  = 1'b1;
        enc_code = ERR_ILLEGAL;
      end
    endcase
  end

  assign in_ready_o = (state_q == S_IDLE) && !full_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    target_d    = target_q;
    pc_d        = pc_q;
    count_d     = count_q;
    full_d      = full_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    chk_d       = chk_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    case (state_q)
      S_IDLE: begin
        // flush wins over a simultaneous request
        if (flush_i) begin
          pc_d    = BASE_L;
          count_d = '0;
          full_d  = 1'b0;
          chk_d   = 32'h0;
        end else if (in_valid_i && in_ready_o) begin
          op_d     = op_i;
          rs_d     = rs_i;
          rt_d     = rt_i;
          rd_d     = rd_i;
          imm_d    = imm_i;
          target_d = target_i;
          state_d  = S_ENCODE;
        end
      end
      S_ENCODE: begin
        if (enc_err) begin
          err_valid_d = 1'b1;
          err_code_d  = enc_code;
          state_d     = S_IDLE;
        end else begin
          we_d    = 1'b1;
          addr_d  = pc_q;
          data_d  = word;
          chk_d   = chk_q ^ word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        pc_d    = pc_q + ADDR_W'(4);
        count_d = count_q + 1'b1;
        full_d  = ((count_q + 1'b1) == MEM_WORDS_L);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      op_q        <= 4'h0;
      rs_q        <= 5'h0;
      rt_q        <= 5'h0;
      rd_q        <= 5'h0;
      imm_q       <= 16'h0;
      target_q    <= 32'h0;
      pc_q        <= BASE_L;
      count_q     <= '0;
      full_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= BASE_L;
      data_q      <= 32'h0;
      chk_q       <= 32'h0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      target_q    <= target_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      full_q      <= full_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign err_valid_o = err_valid_q;
  assign err_code_o  = err_code_q;
  assign full_o      = full_q;
  assign count_o     = count_q;
`ifdef ENCODER_CHECKSUM_EN
  assign checksum_o  = chk_q;
`else
  logic unused_chk;
  assign unused_chk = ^chk_q;
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed spec scenarios plus randomized requests
// checked against an arithmetic encoding model.
module tb_mips_instr_encoder;
  localparam int AW = 10;
  localparam int MW = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0;
  logic in_ready, mem_we, err_valid, full;
  logic [3:0] op = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [31:0] target = '0, mem_data;
  logic [AW-1:0] mem_addr, count;
  logic [1:0] err_code;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mips_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .MEM_WORDS(MW)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .target_i(target),
    .flush_i(flush), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .err_valid_o(err_valid), .err_code_o(err_code), .full_o(full), .count_o(count)
`ifdef ENCODER_CHECKSUM_EN
    , .checksum_o(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int m_pc = 0, m_count = 0;
  bit m_full = 0;
  logic [31:0] m_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fld(input int opc, input int r_s, input int r_t);
    return (32'(opc) << 26) | (32'(r_s) << 21) | (32'(r_t) << 16);
  endfunction

  // Encoding rules computed directly from the instruction-set definition.
  function automatic void model_enc(input int o, input int r_s, input int r_t, input int r_d,
                                    input int im, input logic [31:0] tgt, input int pc,
                                    output bit ok, output int code, output logic [31:0] w);
    logic [31:0] npc;
    int off;
    npc = 32'(pc) + 32'd4;
    ok = 1; code = 0; w = 0;
    case (o)
      0: w = fld(0, r_s, r_t) | 32'(r_d * 2048) | 32'h20;
      1: w = fld(0, r_s, r_t) | 32'(r_d * 2048) | 32'h22;
      2: w = fld(0, r_s, r_t) | 32'(r_d * 2048) | 32'h2A;
      3: w = fld(0, r_s, 0) | 32'h08;
      4: w = fld('h23, r_s, r_t) | 32'(im);
      5: w = fld('h2B, r_s, r_t) | 32'(im);
      10: w = fld('h0E, r_s, r_t) | 32'(im);
      11: w = fld('h08, r_s, r_t) | 32'(im);
      6, 7: begin
        if (tgt % 4 != 0) begin ok = 0; code = 1; end
        else if (tgt / 32'h1000_0000 != npc / 32'h1000_0000) begin ok = 0; code = 2; end
        else w = fld((o == 6) ? 2 : 3, 0, 0) | ((tgt / 4) % 32'h0400_0000);
      end
      8, 9: begin
        if (tgt % 4 != 0) begin ok = 0; code = 1; end
        else begin
          off = int'(tgt - npc) >>> 2;
          if (off < -32768 || off > 32767) begin ok = 0; code = 2; end
          else w = fld((o == 8) ? 4 : 5, r_s, r_t) | 32'(off & 'hFFFF);
        end
      end
      default: begin ok = 0; code = 0; end
    endcase
  endfunction

  task automatic model_clear();
    m_pc = 0; m_count = 0; m_full = 0; m_chk = 0;
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    model_clear();
  endtask

  // stall_flush: expect the request to be stalled by full, then release it with a flush.
  task automatic send(input int o, input int r_s, input int r_t, input int r_d, input int im,
                      input logic [31:0] tgt, input string tag, input bit stall_flush = 0);
    bit ok; int code; logic [31:0] w; int n;
    @(negedge clk);
    op = 4'(o); rs = 5'(r_s); rt = 5'(r_t); rd = 5'(r_d); imm = 16'(im); target = tgt;
    in_valid = 1;
    if (stall_flush) begin
      for (int i = 0; i < 5; i++) begin
        chk({tag, " stall in_ready"}, 32'(in_ready), 0);
        chk({tag, " stall mem_we"}, 32'(mem_we), 0);
        @(negedge clk);
      end
      flush = 1;
      @(negedge clk); flush = 0;
      model_clear();
    end
    model_enc(o, r_s, r_t, r_d, im, tgt, m_pc, ok, code, w);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, " accept timeout"}, 32'(n >= 50), 0);
    @(posedge clk); #1 in_valid = 0;
    chk({tag, " busy in_ready"}, 32'(in_ready), 0);
    @(posedge clk); #1;
    if (ok) begin
      m_chk ^= w;
      chk({tag, " mem_we"}, 32'(mem_we), 1);
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(m_pc));
      chk({tag, " mem_data"}, mem_data, w);
      chk({tag, " err_valid"}, 32'(err_valid), 0);
`ifdef ENCODER_CHECKSUM_EN
      chk({tag, " checksum"}, checksum, m_chk);
`endif
      m_pc = (m_pc + 4) % (1 << AW);
      m_count++;
      m_full = (m_count == MW);
    end else begin
      chk({tag, " err_valid"}, 32'(err_valid), 1);
      chk({tag, " err_code"}, 32'(err_code), 32'(code));
      chk({tag, " no mem_we"}, 32'(mem_we), 0);
    end
    @(posedge clk); #1;
    chk({tag, " we low"}, 32'(mem_we), 0);
    chk({tag, " err low"}, 32'(err_valid), 0);
    chk({tag, " count"}, 32'(count), 32'(m_count));
    chk({tag, " full"}, 32'(full), 32'(m_full));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(!m_full));
  endtask

  initial begin
    #12 reset = 0;
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_data", mem_data, 0);
    chk("rst err_valid", 32'(err_valid), 0);
    chk("rst err_code", 32'(err_code), 0);
    chk("rst full", 32'(full), 0);
    chk("rst count", 32'(count), 0);

    send(0, 1, 2, 3, 0, 0, "t1 add");
    chk("t1 const", mem_data, 32'h0022_1820);

    do_flush();
    send(0, 0, 0, 0, 0, 0, "t2 nop0");
    send(0, 0, 0, 0, 0, 0, "t2 nop1");
    send(8, 1, 2, 0, 0, 32'h0, "t2 beq");
    chk("t2 const", mem_data, 32'h1022_FFFD);
    chk("t2 addr", 32'(mem_addr), 8);

    do_flush();
    send(6, 0, 0, 0, 0, 32'h40, "t3 j");
    chk("t3 j const", mem_data, 32'h0800_0010);
    send(7, 0, 0, 0, 0, 32'h40, "t3 jal");
    chk("t3 jal const", mem_data, 32'h0C00_0010);

    do_flush();
    send(9, 1, 2, 0, 0, 32'h42, "t4 bne misaligned");
    chk("t4 mis code", 32'(err_code), 1);
    send(8, 1, 2, 0, 0, 32'h40000, "t4 beq range");
    chk("t4 range code", 32'(err_code), 2);
    send(13, 0, 0, 0, 0, 0, "t4 illegal");
    chk("t4 illegal code", 32'(err_code), 0);
    send(4, 3, 4, 0, 'h1234, 0, "t4 lw after errors");
    chk("t4 pc unchanged", 32'(mem_addr), 0);

    send(5, 1, 1, 0, 8, 0, "t5 w2");
    send(10, 2, 3, 0, 'hFFFF, 0, "t5 w3");
    send(11, 4, 5, 0, 'h8000, 0, "t5 w4");
    chk("t5 full", 32'(full), 1);
    send(1, 7, 8, 9, 0, 0, "t5 stalled", 1);
    chk("t5 base addr", 32'(mem_addr), 0);

    // flush and request together: request must not be accepted
    @(negedge clk); in_valid = 1; op = 0; flush = 1;
    @(posedge clk); #1 in_valid = 0; flush = 0; model_clear();
    chk("flush prio in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("flush prio mem_we", 32'(mem_we), 0);
    chk("flush prio count", 32'(count), 0);

    // reset during WRITE
    @(negedge clk); op = 0; rs = 1; rt = 2; rd = 3; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1;
    chk("t6 in write", 32'(mem_we), 1);
    #1 reset = 1;
    #1;
    chk("t6 rst mem_we", 32'(mem_we), 0);
    chk("t6 rst count", 32'(count), 0);
    chk("t6 rst addr", 32'(mem_addr), 0);
    @(negedge clk); reset = 0; model_clear();
    send(0, 1, 2, 3, 0, 0, "t6 add");
    chk("t6 pc base", 32'(mem_addr), 0);
    send(6, 0, 0, 0, 0, 32'h40, "t6 j");
`ifdef ENCODER_CHECKSUM_EN
    chk("t6 checksum const", checksum, 32'h0822_1830);
`endif

    for (int i = 0; i < 60; i++) begin
      int o, sel;
      logic [31:0] tgt;
      if (m_full || $urandom_range(0, 9) == 0) do_flush();
      o = $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      case (sel)
        0: tgt = 32'(m_pc) + 32'($urandom_range(0, 64) * 4) - 32'd128;
        1: tgt = $urandom | 32'h1;
        2: tgt = $urandom & 32'h0FFF_FFFC;
        default: tgt = $urandom;
      endcase
      send(o, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 65535), tgt, $sformatf("rnd%0d op%0d", i, o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
